// File: rtl/adat_rx_param.sv
`timescale 1ns/1ps
// ADAT optical-line receiver.
// Recovers NRZI bits from an oversampled line and finds the 10-bit sync gap.
// It then captures the 245-bit field, checks the separator bits and delivers
// the channel samples and the user nibble through a valid/ready port.
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   adat_in        raw asynchronous NRZI line
//   m_valid/ready  frame handshake; m_data holds NUM_CH x SAMPLE_W samples, m_user the user nibble
//   locked         LOCK_FRAMES consecutive good frames have been seen
//   frame_err      one-clock pulse for each rejected frame
//   overrun        sticky; a good frame was dropped while output was held
module adat_rx_param #(
    parameter int CLK_PER_BIT = 8,
    parameter int NUM_CH      = 8,
    parameter int SAMPLE_W    = 24,
    parameter int SYNC_CLKS   = 60,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adat_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_CH*SAMPLE_W-1:0] m_data,
    output logic [3:0]                 m_user,
    output logic                       locked,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int FIELD_BITS = 245;
    localparam int PH_W       = $clog2(CLK_PER_BIT);
    localparam int GAP_W      = $clog2(SYNC_CLKS + 2);
    localparam int GOOD_W     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, HUNT, ALIGN, SHIFT, CHECK} state_t;

    state_t                   state, state_next;
    logic                     sync1, sync2, sync_prev;
    logic                     trans;
    logic [GAP_W-1:0]         gap_cnt;
    logic                     gap_over;
    logic [PH_W-1:0]          phase;
    logic                     sample_en;
    logic                     start;
    logic                     done;
    logic [7:0]               bit_cnt;
    logic                     prev_sample;
    logic                     gap_bad;
    logic [FIELD_BITS-1:0]    field;
    logic                     sep_ok;
    logic                     pass;
    logic                     load;
    logic [23:0]              word;
    logic [NUM_CH*SAMPLE_W-1:0] frame_data;
    logic [GOOD_W-1:0]        good_cnt, good_next;

    assign trans     = sync2 ^ sync_prev;
    assign gap_over  = gap_cnt > GAP_W'(SYNC_CLKS);
    assign start     = (state == ALIGN) && trans;
    assign sample_en = (state == SHIFT) && (phase == PH_W'(CLK_PER_BIT / 2 - 1));
    assign done      = sample_en && (bit_cnt == 8'(FIELD_BITS));

    // Synchroniser plus the previous-value flop used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= adat_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            phase   <= '0;
        end else begin
            if (trans)
                gap_cnt <= '0;
            else if (gap_cnt != '1)
                gap_cnt <= gap_cnt + 1'b1;

            if (trans || start)
                phase <= '0;
            else if (phase == PH_W'(CLK_PER_BIT - 1))
                phase <= '0;
            else
                phase <= phase + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = HUNT;
            HUNT:    if (gap_over) state_next = ALIGN;
            ALIGN:   if (trans) state_next = SHIFT;
            SHIFT:   if (done) state_next = CHECK;
            CHECK:   state_next = HUNT;
            default: state_next = IDLE;
        endcase
    end

    // Sample 0 falls inside the sync '1' and only seeds the NRZI reference;
    // samples 1..245 are the decoded field bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            prev_sample <= 1'b0;
            gap_bad     <= 1'b0;
            field       <= '0;
        end else if (start) begin
            bit_cnt <= '0;
            gap_bad <= 1'b0;
        end else if (state == SHIFT) begin
            if (gap_over)
                gap_bad <= 1'b1;
            if (sample_en) begin
                prev_sample <= sync2;
                bit_cnt     <= bit_cnt + 1'b1;
                if (bit_cnt != '0)
                    field <= {field[FIELD_BITS-2:0], sync2 ^ prev_sample};
            end
        end
    end

    // Field offset i sits at field[FIELD_BITS-1-i].
    always_comb begin
        sep_ok = 1'b1;
        for (int unsigned j = 0; j < 49; j++)
            sep_ok = sep_ok & field[FIELD_BITS - 5 - 5 * j];
    end

    always_comb begin
        frame_data = '0;
        word       = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < 6; k++)
                word[23 - 4 * k -: 4] = field[FIELD_BITS - 6 - 30 * c - 5 * k -: 4];
            frame_data[c * SAMPLE_W +: SAMPLE_W] = word[23 -: SAMPLE_W];
        end
    end

    assign pass      = sep_ok && !gap_bad;
    assign load      = (state == CHECK) && pass && locked && (!m_valid || m_ready);
    assign good_next = (good_cnt == GOOD_W'(LOCK_FRAMES)) ? good_cnt : good_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            good_cnt  <= '0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_user    <= '0;
        end else begin
            frame_err <= 1'b0;
            if (state == CHECK) begin
                if (!pass) begin
                    frame_err <= 1'b1;
                    good_cnt  <= '0;
                    locked    <= 1'b0;
                end else begin
                    good_cnt <= good_next;
                    if (good_next == GOOD_W'(LOCK_FRAMES))
                        locked <= 1'b1;
                    if (locked && m_valid && !m_ready)
                        overrun <= 1'b1;
                end
            end

            if (load) begin
                m_valid <= 1'b1;
                m_data  <= frame_data;
                m_user  <= field[FIELD_BITS-1 -: 4];
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adat_rx_param.sv
`timescale 1ns/1ps
// Bench for adat_rx_param: builds ADAT frames from sample values, NRZI-encodes
// them onto the line and compares outputs with a frame-level model.
module tb_adat_rx_param;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         adat_in;
    logic         m_ready;
    logic         m_valid, locked, frame_err, overrun;
    logic [191:0] m_data;
    logic [3:0]   m_user;
    logic         m_valid2, locked2, frame_err2, overrun2;
    logic [31:0]  m_data2;
    logic [3:0]   m_user2;
    logic         ready2 = 1'b1;

    always #5 clk = ~clk;

    adat_rx_param u_dut (
        .clk(clk), .rst_n(rst_n), .adat_in(adat_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user),
        .locked(locked), .frame_err(frame_err), .overrun(overrun)
    );

    adat_rx_param #(.NUM_CH(2), .SAMPLE_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .adat_in(adat_in),
        .m_valid(m_valid2), .m_ready(ready2), .m_data(m_data2), .m_user(m_user2),
        .locked(locked2), .frame_err(frame_err2), .overrun(overrun2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Output monitor (sampled on the falling edge).
    int           n_vcyc = 0, n_ecyc = 0, n_hs = 0, n_hs2 = 0, n_unstable = 0;
    logic [191:0] hs_data = '0, pd = '0;
    logic [3:0]   hs_user = '0;
    logic [31:0]  hs_data2 = '0;
    logic         pv = 1'b0, pr = 1'b0;

    always @(negedge clk) begin
        if (m_valid) n_vcyc++;
        if (frame_err) n_ecyc++;
        if (m_valid && m_ready) begin
            n_hs++;
            hs_data = m_data;
            hs_user = m_user;
        end
        if (pv && !pr && (!m_valid || m_data !== pd)) n_unstable++;
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
        if (m_valid2) begin
            n_hs2++;
            hs_data2 = m_data2;
        end
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    // Frame model state
    logic [23:0] ch [8];
    logic        line = 1'b0;
    int          good_frames = 0;
    bit          mlocked = 1'b0;
    int          fno = 0;

    function automatic logic [191:0] exp_vec();
        logic [191:0] v;
        for (int c = 0; c < 8; c++) v[c*24 +: 24] = ch[c];
        return v;
    endfunction

    function automatic logic [191:0] exp_vec2();
        logic [23:0] a, b;
        a = ch[0];
        b = ch[1];
        return {160'd0, b[23:8], a[23:8]};
    endfunction

    task automatic randomize_channels();
        for (int c = 0; c < 8; c++) ch[c] = 24'($urandom());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_user"}, m_user, 0);
        check({tag, "_m_data2"}, m_data2, 0);
    endtask

    // Sends 10 idle bits, the sync '1' and the 245-bit field.
    task automatic send_frame(input logic [3:0] user, input int bad_sep,
                              input bit jitter, input int abort_at);
        logic fbits [245];
        int   o;
        logic v;
        o = 0;
        for (int j = 0; j < 4; j++) begin fbits[o] = user[3-j]; o++; end
        fbits[o] = 1'b1; o++;
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 6; k++) begin
                for (int j = 0; j < 4; j++) begin fbits[o] = ch[c][23-4*k-j]; o++; end
                fbits[o] = 1'b1; o++;
            end
        if (bad_sep >= 0) fbits[bad_sep] = 1'b0;
        for (int b = 0; b < 256; b++) begin
            if (abort_at >= 0 && b == 11 + abort_at) begin
                rst_n = 1'b0;
                hold(3);
                rst_n = 1'b1;
                tick();
                check_reset_outputs("midreset");
            end
            v = (b < 10) ? 1'b0 : (b == 10) ? 1'b1 : fbits[b-11];
            if (v) line = ~line;
            adat_in = line;
            hold(jitter ? ((b % 2 == 1) ? 9 : 7) : 8);
        end
    endtask

    // One frame with m_ready=1, checked against the lock/output model.
    task automatic run_frame(input logic [3:0] user, input int bad_sep, input bit jitter);
        int  hs0, vc0, ec0, hs20;
        bit  good, exp_out;
        hs0 = n_hs; vc0 = n_vcyc; ec0 = n_ecyc; hs20 = n_hs2;
        fno++;
        send_frame(user, bad_sep, jitter, -1);
        hold(24);
        good    = (bad_sep < 0);
        exp_out = good && mlocked;
        if (good) good_frames = (good_frames < 4) ? good_frames + 1 : 4;
        else      good_frames = 0;
        mlocked = (good_frames >= 4);
        check($sformatf("f%0d_locked", fno), locked, mlocked);
        check($sformatf("f%0d_err_cycles", fno), n_ecyc - ec0, good ? 0 : 1);
        check($sformatf("f%0d_handshakes", fno), n_hs - hs0, exp_out);
        check($sformatf("f%0d_valid_cycles", fno), n_vcyc - vc0, exp_out);
        check($sformatf("f%0d_out2_count", fno), n_hs2 - hs20, exp_out);
        if (exp_out) begin
            check($sformatf("f%0d_data", fno), hs_data, exp_vec());
            check($sformatf("f%0d_user", fno), hs_user, user);
            check($sformatf("f%0d_data2", fno), hs_data2, exp_vec2());
        end
    endtask

    initial begin
        logic [191:0] held;
        logic [3:0]   u;
        int           hs0, ec0, un0;

        rst_n   = 1'b0;
        adat_in = 1'b0;
        m_ready = 1'b1;
        hold(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        hold(160);

        // Lock-up on four frames, first output on the fifth.
        for (int i = 0; i < 5; i++) begin
            randomize_channels();
            ch[0] = 24'h123456;
            ch[7] = 24'hABCDEF;
            run_frame(4'hA, -1, 1'b0);
        end

        // Random payloads, then a 7/9 jittered bit period.
        for (int i = 0; i < 6; i++) begin
            randomize_channels();
            u = 4'($urandom());
            run_frame(u, -1, i >= 3);
        end

        // Broken separator at offset 9 drops lock; four good frames relock.
        randomize_channels();
        run_frame(4'h5, 9, 1'b0);
        for (int i = 0; i < 5; i++) begin
            randomize_channels();
            run_frame(4'($urandom()), -1, 1'b0);
        end

        // Consumer stalls for three frames.
        m_ready = 1'b0;
        hs0 = n_hs; ec0 = n_ecyc; un0 = n_unstable;
        randomize_channels();
        held = exp_vec();
        send_frame(4'h3, -1, 1'b0, -1);
        hold(24);
        check("stall1_valid", m_valid, 1);
        check("stall1_data", m_data, held);
        check("stall1_overrun", overrun, 0);
        for (int i = 2; i <= 3; i++) begin
            randomize_channels();
            send_frame(4'hC, -1, 1'b0, -1);
            hold(24);
            check($sformatf("stall%0d_valid", i), m_valid, 1);
            check($sformatf("stall%0d_data", i), m_data, held);
            check($sformatf("stall%0d_overrun", i), overrun, 1);
        end
        check("stall_unstable", n_unstable - un0, 0);
        check("stall_err", n_ecyc - ec0, 0);
        m_ready = 1'b1;
        hold(2);
        check("stall_release_hs", n_hs - hs0, 1);
        check("stall_release_data", hs_data, held);
        check("stall_release_user", hs_user, 4'h3);
        check("stall_release_valid", m_valid, 0);
        check("stall_overrun_sticky", overrun, 1);

        // Narrow instance keeps the upper 16 bits of each sample.
        randomize_channels();
        ch[0] = 24'h80FFEE;
        run_frame(4'h6, -1, 1'b0);
        check("narrow_ch0", hs_data2[15:0], 16'h80FF);

        // Reset at field bit 100, then relock from scratch without errors.
        ec0 = n_ecyc;
        randomize_channels();
        send_frame(4'h9, -1, 1'b0, 100);
        hold(24);
        good_frames = 0;
        mlocked     = 1'b0;
        check("after_reset_locked", locked, 0);
        check("after_reset_overrun", overrun, 0);
        check("after_reset_valid", m_valid, 0);
        for (int i = 0; i < 5; i++) begin
            randomize_channels();
            run_frame(4'($urandom()), -1, 1'b0);
        end
        check("after_reset_err_total", n_ecyc - ec0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adat_rx_param.md
ADAT_RX_PARAM -- requirements
Module: adat_rx_param

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 8, meaning system clocks per ADAT bit (98.304 MHz / 12.288 Mbit/s); legal range 6..16.
REQ-002 SHALL have parameter NUM_CH, default 8, meaning channels delivered, taken from frame channels 0..NUM_CH-1; legal range 1..8.
REQ-003 SHALL have parameter SAMPLE_W, default 24, meaning output sample width; legal range 16..24; when below 24 the output is the upper SAMPLE_W bits of the 24-bit word.
REQ-004 SHALL have parameter SYNC_CLKS, default 60, meaning the count of transition-free clocks that identifies the sync gap.
REQ-005 SHALL have parameter LOCK_FRAMES, default 4, meaning the number of consecutive good frames required to assert locked.
REQ-006 clk  input  1  system clock; one clock domain; reset is synchronous and active-low.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 adat_in  input  1  raw asynchronous NRZI ADAT line.
REQ-009 m_valid  output  1  frame available.
REQ-010 m_ready  input  1  consumer accepts the frame.
REQ-011 m_data  output  NUM_CH*SAMPLE_W  signed samples; channel c at bits [c*SAMPLE_W +: SAMPLE_W].
REQ-012 m_user  output  4  user nibble {timecode, midi, smux, reserved}.
REQ-013 locked  output  1  receiver is locked.
REQ-014 frame_err  output  1  one-clock pulse on each rejected frame.
REQ-015 overrun  output  1  sticky; a frame was dropped while m_valid was held.

Function
REQ-016 adat_in SHALL pass through a 2-flop synchroniser; a transition is defined as synchronised bit != its previous value.
REQ-017 FSM states SHALL be IDLE, HUNT, ALIGN, SHIFT, CHECK.
- IDLE->HUNT: one clock after reset release.
- HUNT->ALIGN: gap counter > SYNC_CLKS.
- ALIGN->SHIFT: first transition.
- SHIFT->CHECK: 245th data bit captured.
- CHECK->HUNT: always.
REQ-018 The gap counter SHALL clear on every transition, saturate at its maximum, and run in all states.
REQ-019 The bit-phase counter SHALL clear on every transition and on ALIGN->SHIFT, and wrap at CLK_PER_BIT-1; a bit SHALL be sampled when phase == CLK_PER_BIT/2-1. This re-centres sampling on every edge, which is new behaviour.
REQ-020 The decoded bit SHALL be (sample XOR previous sample); 245 bits SHALL be shifted MSB-first after the sync '1'.
REQ-021 CHECK SHALL verify that the separator bits at offsets 4, 9, ..., 244 of the 245-bit field are all 1. The gap counter SHALL also not have exceeded SYNC_CLKS during SHIFT.
REQ-022 Any CHECK failure SHALL pulse frame_err, clear the good-frame counter, deassert locked, and produce no output.
REQ-023 A passing frame SHALL increment the good-frame counter, saturating; locked SHALL assert when the counter reaches LOCK_FRAMES.
REQ-024 A passing frame while locked SHALL load m_data/m_user and assert m_valid in the clock after CHECK. Latency is 1 clock from CHECK.
REQ-025 Handshake:
- m_valid and m_data SHALL stay stable until the m_valid&&m_ready clock.
- m_valid SHALL drop the next clock unless a new frame loads in that same clock, in which case m_valid stays 1 with the new data.
REQ-026 A new passing frame arriving while m_valid=1 and m_ready=0 SHALL be dropped, the old data retained, and overrun set.
REQ-027 overrun SHALL clear only on reset.
REQ-028 Channel c nibbles SHALL be taken from field offsets 5+30c+5k, k=0..5, MSB nibble first.

Reset
REQ-029 With rst_n=0 at a clock edge, the next state SHALL be:
- state IDLE
- m_valid=0, locked=0, frame_err=0, overrun=0
- m_data=0, m_user=0
- counters=0
REQ-030 Reset mid-frame or mid-handshake SHALL discard the frame and pending output without emitting frame_err.
REQ-031 The synchroniser flops and the gap counter SHALL also reset: synchroniser to 0, gap counter to 0.

Verification
REQ-032 Default parameters, 4 valid frames, ch0=0x123456, ch7=0xABCDEF, user=0xA, m_ready=1 -> locked rises after frame 4 CHECK; frame 5 outputs ch0=0x123456, ch7=0xABCDEF, m_user=0xA, with m_valid high for 1 clock.
REQ-033 Locked stream, separator bit 9 forced to 0 in one frame -> one-clock frame_err pulse, locked=0, no m_valid; relock after 4 further good frames.
REQ-034 Locked stream, m_ready=0 for 3 frames -> first frame held stable; overrun=1 after the 2nd frame; the first frame is delivered when m_ready rises.
REQ-035 CLK_PER_BIT=8 with source bit period jittered to 7/9 clocks, alternating -> all frames pass with no frame_err.
REQ-036 NUM_CH=2, SAMPLE_W=16, ch0=0x80FFEE -> m_data[15:0]=0x80FF; m_data is 32 bits wide.
REQ-037 rst_n=0 at bit 100 of a frame, then released -> all outputs 0; next valid frame resumes hunting, with no frame_err.
